// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared types and defaults for the pixel writer path:
//                controller state encoding, default screen geometry and the
//                packed pixel record carried through the pixel FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

  localparam int SCR_W_DEFAULT = 160;
  localparam int SCR_H_DEFAULT = 120;

  // Controller states: CLEAR sweeps the whole screen, STREAM drains the FIFO.
  typedef enum logic [0:0] {
    ST_CLEAR  = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Pixel as stored in the FIFO, already truncated to VGA adapter widths.
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fifo
//  Description : Synchronous pixel FIFO with flush. A flush empties the FIFO;
//                a push in the flush cycle is kept as the only entry. A push
//                while full is taken only when a pop happens in the same cycle.
//  Ports       : clk      - clock, rising edge
//                rst_n    - asynchronous active-low reset (empties FIFO)
//                flush    - discard all entries
//                push     - write request for wr_data
//                pop      - read request; rd_data is the head entry
//                wr_data  - pixel to store
//                rd_data  - head-of-queue pixel (valid when !empty)
//                full     - DEPTH entries stored
//                empty    - no entries stored
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  pixel_t wr_data,
  output pixel_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    c_depth = (AW + 1)'(DEPTH);

  pixel_t        mem_q [DEPTH];
  pixel_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == c_depth);
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (push) begin
        mem_d[0] = wr_data;
        wr_ptr_d = AW'(1);
        count_d  = (AW + 1)'(1);
      end
    end else begin
      // When full, the slot being written is the one popped this cycle; the
      // read side sees the old contents because rd_data comes from mem_q.
      do_push = push && (!full || pop);
      do_pop  = pop && !empty;
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + (AW + 1)'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_writer
//  Description : Feeds a VGA adapter. After reset or a clear request it
//                sweeps the whole screen with CLEAR_COLOR (x fastest), then
//                streams queued pixels from the line-drawing FSM, one per
//                cycle. Out-of-range pixels are discarded.
//  Ports       : clk        - clock, rising edge
//                reset      - asynchronous active-low reset
//                x_in/y_in  - 9-bit pixel coordinates
//                color_in   - 3-bit pixel colour
//                write_in   - pixel valid strobe
//                clear_req  - single-cycle screen clear request
//                ready      - offered pixel will be accepted this cycle
//                vga_x/vga_y/vga_colour/vga_plot - VGA adapter write port
//                busy       - clear sweep in progress
//                overflow   - sticky: an in-range pixel was dropped
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_writer
  import vga_pkg::*;
#(
  parameter int         SCR_W       = SCR_W_DEFAULT,
  parameter int         SCR_H       = SCR_H_DEFAULT,
  parameter int         DEPTH       = 16,
  parameter logic [2:0] CLEAR_COLOR = 3'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] x_in,
  input  logic [8:0] y_in,
  input  logic [2:0] color_in,
  input  logic       write_in,
  input  logic       clear_req,
  output logic       ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       overflow
);

  localparam logic [8:0] c_scr_w  = 9'(SCR_W);
  localparam logic [8:0] c_scr_h  = 9'(SCR_H);
  localparam logic [7:0] c_x_last = 8'(SCR_W - 1);
  localparam logic [6:0] c_y_last = 7'(SCR_H - 1);

  state_e     state_q,      state_d;
  logic [7:0] sweep_x_q,    sweep_x_d;
  logic [6:0] sweep_y_q,    sweep_y_d;
  logic [7:0] vga_x_q,      vga_x_d;
  logic [6:0] vga_y_q,      vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q,   vga_plot_d;
  logic       overflow_q,   overflow_d;

  logic       in_range;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       drop;
  pixel_t     fifo_wr;
  pixel_t     fifo_rd;

  // Range check is done on the full 9-bit inputs before truncation.
  assign in_range = (x_in < c_scr_w) && (y_in < c_scr_h);
  assign fifo_wr  = '{x: x_in[7:0], y: y_in[6:0], colour: color_in};

  // A clear request pre-empts the pop: the queue is being flushed anyway.
  assign fifo_pop  = (state_q == ST_STREAM) && !fifo_empty && !clear_req;
  assign ready     = !fifo_full || fifo_pop || clear_req;
  assign fifo_push = write_in && in_range && ready;
  assign drop      = write_in && in_range && !ready;

  always_comb begin
    state_d      = state_q;
    sweep_x_d    = sweep_x_q;
    sweep_y_d    = sweep_y_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    overflow_d   = overflow_q;

    if (clear_req) begin
      // Restart the sweep; the first clear plot lands on the following edge.
      state_d    = ST_CLEAR;
      sweep_x_d  = '0;
      sweep_y_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (drop) begin
        overflow_d = 1'b1;
      end
      case (state_q)
        ST_CLEAR: begin
          vga_plot_d   = 1'b1;
          vga_x_d      = sweep_x_q;
          vga_y_d      = sweep_y_q;
          vga_colour_d = CLEAR_COLOR;
          if (sweep_x_q == c_x_last) begin
            sweep_x_d = '0;
            if (sweep_y_q == c_y_last) begin
              sweep_y_d = '0;
              state_d   = ST_STREAM;
            end else begin
              sweep_y_d = sweep_y_q + 7'd1;
            end
          end else begin
            sweep_x_d = sweep_x_q + 8'd1;
          end
        end
        ST_STREAM: begin
          if (fifo_pop) begin
            vga_plot_d   = 1'b1;
            vga_x_d      = fifo_rd.x;
            vga_y_d      = fifo_rd.y;
            vga_colour_d = fifo_rd.colour;
          end
        end
        default: begin
          state_d = ST_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_CLEAR;
      sweep_x_q    <= '0;
      sweep_y_q    <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_x_q    <= sweep_x_d;
      sweep_y_q    <= sweep_y_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      overflow_q   <= overflow_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == ST_CLEAR);

  pixel_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush   (clear_req),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
`default_nettype wire

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameter SCR_W, default 160, visible screen width in pixels.
REQ-002 Parameter SCR_H, default 120, visible screen height in pixels.
REQ-003 Parameter DEPTH, default 16, pixel FIFO depth (power of two).
REQ-004 Parameter CLEAR_COLOR, default 3'd0, colour written during a clear sweep.
REQ-005 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 x_in  input  9  pixel x from the line-drawing FSM.
REQ-008 y_in  input  9  pixel y from the line-drawing FSM.
REQ-009 color_in  input  3  pixel colour from the line-drawing FSM.
REQ-010 write_in  input  1  pixel valid strobe; one pixel per high cycle.
REQ-011 clear_req  input  1  single-cycle request to blank the screen.
REQ-012 ready  output  1  high when a pixel offered this cycle will be accepted (FIFO not full, or full with a pop this cycle).
REQ-013 vga_x  output  8  VGA adapter x.
REQ-014 vga_y  output  7  VGA adapter y.
REQ-015 vga_colour  output  3  VGA adapter colour.
REQ-016 vga_plot  output  1  VGA adapter write enable, one pixel per high cycle.
REQ-017 busy  output  1  high while a clear sweep runs.
REQ-018 overflow  output  1  sticky; set when a valid in-range pixel is dropped because the FIFO is full.

Function
REQ-019 The block SHALL have two states, CLEAR and STREAM.
REQ-020 CLEAR SHALL emit one pixel per cycle with CLEAR_COLOR, x fastest (0..SCR_W-1), then y (0..SCR_H-1), for SCR_W*SCR_H = 19200 plots total.
REQ-021 After the plot at (SCR_W-1, SCR_H-1), the next state SHALL be STREAM, and busy SHALL fall in the same cycle.
REQ-022 In STREAM, one FIFO entry SHALL be popped per cycle when the FIFO is non-empty, and driven on the vga_* outputs with vga_plot=1 on the following cycle.
REQ-023 A pixel presented with write_in at cycle N to an empty FIFO in STREAM SHALL appear with vga_plot=1 at cycle N+2.
REQ-024 Pixels with x_in>=SCR_W or y_in>=SCR_H SHALL be discarded without a FIFO write and without setting overflow.
REQ-025 In-range pixels SHALL be written to the FIFO in both states; during CLEAR they accumulate and are never popped.
REQ-026 A write to a full FIFO with a pop in the same cycle SHALL be accepted.
REQ-027 A write to a full FIFO without a pop SHALL be dropped, and overflow SHALL be set.
REQ-028 clear_req in either state SHALL flush the FIFO, restart the sweep at (0,0) in CLEAR on the next cycle, and clear overflow.
REQ-029 A pixel with write_in in the same cycle as clear_req SHALL be kept as the sole FIFO entry after the flush.
REQ-030 vga_plot SHALL be 0 in every cycle without a clear pixel or popped pixel; vga_x, vga_y and vga_colour SHALL hold their last values.
REQ-031 Pixels SHALL leave in acceptance order; x_in/y_in SHALL be truncated to 8/7 bits only after the range check.

Reset
REQ-032 While reset=0, the outputs SHALL be: vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, overflow=0, busy=1, ready=1; the FIFO SHALL be empty and the state SHALL be CLEAR at (0,0).
REQ-033 The first clear plot SHALL occur in the first rising edge after reset deasserts, so a full sweep follows every reset.
REQ-034 Reset asserted mid-sweep or mid-drain SHALL abort immediately and discard all FIFO contents.

Structure
REQ-035 The shared package (vga_pkg) SHALL hold the state enum, the SCR_W/SCR_H defaults and the pixel struct {x[7:0], y[6:0], colour[2:0]}.
REQ-036 The FIFO SHALL be one sub-module, pixel_fifo (synchronous, DEPTH entries, full/empty flags, flush input); the sweep counters and state machine SHALL live in pixel_writer.

Verification
REQ-037 Reset release -> exactly 19200 plots of colour 0 covering every (x,y) once, busy high throughout the sweep, then busy=0.
REQ-038 In STREAM, write (10,10,c=1) at cycle N -> vga_plot at N+2 with vga_x=10, vga_y=10, vga_colour=1.
REQ-039 20 pixels written during CLEAR -> first 16 drained in order after the sweep, 4 dropped, overflow=1.
REQ-040 Write (160,5) and (5,120) -> no plot and overflow stays 0; write (159,119) -> plotted.
REQ-041 clear_req with 8 entries queued and a simultaneous write of (105,9,c=3) -> new sweep from (0,0), then a single plot at (105,9) colour 3.
REQ-042 Reset asserted at sweep pixel 5000 -> vga_plot=0 immediately; after release the sweep restarts at (0,0).
